timestamp_capture: RTL

Downstream consumer of the free-running 64-bit event counter: snoops the counter value and, on each rising edge of an asynchronous event input, captures the current count into a small first-word-fall-through FIFO drained over a valid/ready interface. Sits between the counter and the host-side readout logic. Gives the readout path exact event timestamps without stalling the counter.

---
 rtl/timestamp_capture_pkg.sv | 12 +
 rtl/timestamp_capture_sync_edge.sv | 26 ++
 rtl/timestamp_capture.sv | 93 +++++++++
 3 files changed

// File: rtl/timestamp_capture_pkg.sv
// rtl/timestamp_capture_pkg.sv - shared widths and pointer type for the timestamp capture block
package timestamp_capture_pkg;

  localparam int TS_WIDTH = 64;
  localparam int DROP_W   = 8;
  localparam int TS_DEPTH = 4;
  localparam int TS_PTR_W = $clog2(TS_DEPTH) + 1;

  // Extra MSB distinguishes full from empty when the index bits match
  typedef logic [TS_PTR_W-1:0] ts_fifo_ptr_t;

endpackage

// File: rtl/timestamp_capture_sync_edge.sv
// rtl/timestamp_capture_sync_edge.sv - event_in synchronizer and one-cycle rising-edge detector
module ts_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic event_in,
  output logic det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign det = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/timestamp_capture.sv
// rtl/timestamp_capture.sv - captures count_in on each event_in rising edge into a FWFT FIFO
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int WIDTH       = TS_WIDTH,
  parameter int DEPTH       = TS_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     event_in,
  output logic [WIDTH-1:0]         ts_out,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  input  logic                     clear_ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  level_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_count_q;

  logic det;
  logic full;
  logic pop;
  logic push;
  logic drop;

  ts_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clock    (clock),
    .rst_n    (rst_n),
    .event_in (event_in),
    .det      (det)
  );

  assign full = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop  = ts_valid & ts_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push = det & (~full | pop);
  assign drop = det & full & ~pop;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= count_in;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_q + PTR_W'(push) - PTR_W'(pop);
    end
  end

  // A drop in the same cycle as clear_ovf leaves a count of one
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q   <= 1'b1;
      if (clear_ovf)
        drop_count_q <= DROP_W'(1);
      else if (drop_count_q != '1)
        drop_count_q <= drop_count_q + DROP_W'(1);
    end else if (clear_ovf) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end
  end

  assign ts_out     = mem[rd_ptr[AW-1:0]];
  assign ts_valid   = (level_q != '0);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
